// File: rtl/button_debounce_pulse_if.sv
// Key-conditioning bundle: raw key and repeat enable in,
// debounced level and decrement strobe out.
interface button_debounce_pulse_if;
  logic btn_in;
  logic repeat_en;
  logic pulse;
  logic pressed;

  modport master (
    output btn_in,
    output repeat_en,
    input  pulse,
    input  pressed
  );

  modport slave (
    input  btn_in,
    input  repeat_en,
    output pulse,
    output pressed
  );
endinterface

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: 2-flop sync, press/release debounce,
// one pulse per accepted press plus optional auto-repeat.
module button_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  button_debounce_pulse_if.slave bif
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                   : REPEAT_PERIOD;
  localparam int unsigned RW = $clog2(RMAX);

  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST =
    RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST =
    RW'(REPEAT_PERIOD - 1);

  // Pin level of a released key; XOR with it yields active-high.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [DBW-1:0] db_cnt;
  logic [DBW-1:0] db_n;
  logic [RW-1:0]  rpt_cnt;
  logic [RW-1:0]  rpt_n;
  logic [RW-1:0]  rpt_last;
  logic           first_done;
  logic           first_n;
  logic           pulse_q;
  logic           pulse_n;
  logic           pressed_q;
  logic           pressed_n;
  logic           sync1;
  logic           sync2;
  logic           raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= bif.btn_in;
      sync2 <= sync1;
    end
  end

  assign raw = sync2 ^ IDLE_LVL;

  assign rpt_last = first_done ? RP_LAST : RD_LAST;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      db_cnt     <= '0;
      rpt_cnt    <= '0;
      first_done <= 1'b0;
      pulse_q    <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      state      <= state_n;
      db_cnt     <= db_n;
      rpt_cnt    <= rpt_n;
      first_done <= first_n;
      pulse_q    <= pulse_n;
      pressed_q  <= pressed_n;
    end
  end

  always_comb begin
    state_n   = state;
    db_n      = db_cnt;
    rpt_n     = rpt_cnt;
    first_n   = first_done;
    pulse_n   = 1'b0;
    pressed_n = pressed_q;
    unique case (state)
      IDLE: begin
        if (raw) begin
          state_n = PRESS_DB;
          db_n    = '0;
        end
      end
      PRESS_DB: begin
        if (!raw) begin
          state_n = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_n   = HELD;
          pulse_n   = 1'b1;
          pressed_n = 1'b1;
          rpt_n     = '0;
          first_n   = 1'b0;
        end else begin
          db_n = db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!raw) begin
          state_n = REL_DB;
          db_n    = '0;
        end else if (!bif.repeat_en) begin
          // Re-enabling must wait the full initial delay again.
          rpt_n   = '0;
          first_n = 1'b0;
        end else if (rpt_cnt == rpt_last) begin
          pulse_n = 1'b1;
          rpt_n   = '0;
          first_n = 1'b1;
        end else begin
          rpt_n = rpt_cnt + 1'b1;
        end
      end
      REL_DB: begin
        // Repeat timing stays frozen across a release glitch.
        if (raw) begin
          state_n = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_n   = IDLE;
          pressed_n = 1'b0;
        end else begin
          db_n = db_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bif.pulse   = pulse_q;
  assign bif.pressed = pressed_q;

  a_no_double: assert property (
    @(posedge clk) disable iff (reset)
    pulse_q |=> !pulse_q
  );

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Randomised and directed bench for button_debounce_pulse
// against a run-length reference model.
module tb_button_debounce_pulse;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk;
  logic rst;
  logic btn;
  logic ren;

  int total;
  int bad;

  button_debounce_pulse_if bif ();

  assign bif.btn_in    = btn;
  assign bif.repeat_en = ren;

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bif   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: key level delayed two edges, then a run-length
  // filter of (raw != accepted level) and an age counter.
  bit m_s1;
  bit m_s2;
  int m_run;
  int m_age;
  bit m_first;
  bit m_pulse;
  bit m_pr;

  int ecnt;
  int pq[$];
  int rise_e;
  int fall_e;
  bit any_pr;
  bit any_low;
  bit prev_pr;

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit raw;
    int thr;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_run = 0; m_age = 0;
      m_first = 0; m_pulse = 0; m_pr = 0;
    end else begin
      raw = m_s2;
      m_pulse = 0;
      if (raw != m_pr) begin
        m_run++;
        if (m_run == D + 1) begin
          m_run = 0;
          m_pr = raw;
          if (raw) begin
            m_pulse = 1; m_age = 0; m_first = 0;
          end
        end
      end else begin
        if (m_pr && m_run == 0) begin
          if (!ren) begin
            m_age = 0; m_first = 0;
          end else begin
            m_age++;
            thr = m_first ? RP : RD;
            if (m_age == thr) begin
              m_pulse = 1; m_age = 0; m_first = 1;
            end
          end
        end
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = ~btn;
    end
  endtask

  task automatic mark();
    ecnt = 0;
    pq.delete();
    rise_e = -1;
    fall_e = -1;
    any_pr = 0;
    any_low = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    ecnt++;
    chk("pulse", int'(bif.pulse), int'(m_pulse));
    chk("pressed", int'(bif.pressed), int'(m_pr));
    if (bif.pulse === 1'b1) pq.push_back(ecnt);
    if (bif.pressed === 1'b1) any_pr = 1;
    else any_low = 1;
    if (bif.pressed && !prev_pr && rise_e < 0)
      rise_e = ecnt;
    if (!bif.pressed && prev_pr && fall_e < 0)
      fall_e = ecnt;
    prev_pr = bif.pressed;
  endtask

  function automatic int nth(int i);
    return (i < pq.size()) ? pq[i] : -1;
  endfunction

  int exp_rep[4] = '{7, 15, 18, 21};
  int pre;
  int post;

  initial begin
    total = 0; bad = 0; prev_pr = 0;
    rst = 1; btn = 1; ren = 0;
    mark();
    repeat (2) tick();

    // Reset held with the key pressed.
    btn = 0;
    tick();
    chk("rst_pulse", int'(bif.pulse), 0);
    chk("rst_pressed", int'(bif.pressed), 0);
    tick();
    chk("rst_pulse2", int'(bif.pulse), 0);
    chk("rst_pressed2", int'(bif.pressed), 0);
    rst = 0;
    mark();
    repeat (10) tick();
    chk("rst_first", nth(0), 7);
    chk("rst_count", pq.size(), 1);
    btn = 1;
    repeat (20) tick();

    // Clean press and release.
    ren = 0; btn = 0;
    mark();
    repeat (30) tick();
    chk("press_count", pq.size(), 1);
    chk("press_edge", nth(0), 7);
    chk("press_rise", rise_e, 7);
    btn = 1;
    mark();
    repeat (20) tick();
    chk("rel_fall", fall_e, 7);
    chk("rel_pulses", pq.size(), 0);

    // Bounce: never four stable pressed samples.
    mark();
    for (int i = 0; i < 10; i++) begin
      btn = 0; tick(); tick(); tick();
      btn = 1; tick();
    end
    repeat (10) tick();
    chk("bounce_pulses", pq.size(), 0);
    chk("bounce_pressed", int'(any_pr), 0);

    // Auto-repeat, enable dropped for edge 22.
    ren = 1; btn = 0;
    mark();
    repeat (21) tick();
    ren = 0;
    repeat (9) tick();
    chk("rep_count", pq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("rep_edge", nth(i), exp_rep[i]);
    btn = 1;
    repeat (20) tick();

    // Release glitch while held.
    btn = 0;
    repeat (15) tick();
    mark();
    btn = 1; tick(); tick();
    btn = 0;
    repeat (20) tick();
    chk("glitch_pulses", pq.size(), 0);
    chk("glitch_low", int'(any_low), 0);
    btn = 1;
    repeat (20) tick();

    // Reset at edge 5 of a press, key kept down.
    btn = 0;
    mark();
    repeat (4) tick();
    rst = 1;
    tick();
    pre = pq.size();
    chk("mid_pre", pre, 0);
    rst = 0;
    mark();
    repeat (12) tick();
    post = pq.size();
    chk("mid_edge", nth(0), 7);
    chk("mid_count", 63 - pre - post, 62);
    btn = 1;
    repeat (20) tick();

    // Random levels with runs of mixed length.
    for (int n = 0; n < 300; n++) begin
      int len;
      btn = 1'($urandom_range(0, 1));
      len = (n % 3 == 0) ? $urandom_range(1, 4)
                         : $urandom_range(1, 30);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 19) == 0) ren = ~ren;
        rst = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    rst = 0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
